fifo_pkt: RTL and testbench
===========================

Name: fifo_pkt

Overview:
- Parametrised successor to the byte FIFO used between the Maple bus PHY and the host interface. Width and depth are configurable.
- Adds packet-level commit/abort so a received frame can be discarded on CRC or timeout error.
- Adds registered almost-full/almost-empty flags and sticky overflow/underflow.
- Reader only ever sees committed entries.

Parameters:
WIDTH, 8, data word width in bits
DEPTH, 16, number of entries, any value >= 2 (not required to be a power of two)
AFULL_THRESH, 2, almost_full asserted when free entries <= this value
AEMPTY_THRESH, 2, almost_empty asserted when committed entries <= this value
CNT_W, derived (clog2(DEPTH+1)), width of count outputs; localparam, not overridable

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
manual_reset  in  1  synchronous clear, same effect as rst on the next edge
indata  in  WIDTH  write data
instrobe  in  1  write request
commit  in  1  publish all pending writes to the reader
abort  in  1  discard all pending (uncommitted) writes
inavail  out  1  at least one free entry
inavail_cnt  out  CNT_W  free entries (DEPTH - pending - committed)
outdata  out  WIDTH  head of committed data (first-word fall-through)
outstrobe  in  1  read/pop request
outavail  out  1  at least one committed entry
outavail_cnt  out  CNT_W  committed entries
pending_cnt  out  CNT_W  written but uncommitted entries
almost_full  out  1  free <= AFULL_THRESH
almost_empty  out  1  committed <= AEMPTY_THRESH
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Pointers: wr_pos (speculative), cm_pos (commit boundary), rd_pos. Each wraps DEPTH-1 -> 0 by compare, not by bit truncation.
- Reset (rst async, or manual_reset sync) values:
  - all pointers 0; inavail=1; inavail_cnt=DEPTH; outavail=0; outavail_cnt=0; pending_cnt=0
  - almost_full = (DEPTH <= AFULL_THRESH); almost_empty=1; overflow=0; underflow=0
  - storage array is not reset.
- All flags and counts are registered and reflect state after the previous edge.
- Write accepted when instrobe && inavail && !abort:
  - mem[wr_pos] <= indata; wr_pos advances; pending +1; free -1.
- instrobe && !inavail && !abort: write is dropped; overflow set.
- Read accepted when outstrobe && outavail: rd_pos advances; committed -1; free +1.
- outstrobe && !outavail: underflow set; no state change.
- commit (without abort): committed += pending (including a write accepted this same cycle); pending=0; cm_pos <= next wr_pos.
- abort: wr_pos <= cm_pos; free += pending; pending=0. An instrobe in the same cycle is ignored and does not set overflow.
- commit && abort in the same cycle: abort wins.
- Simultaneous accepted write and read: both pointers advance; free is unchanged. Committed decrements only if commit is not also asserted.
- Read of the last committed entry while commit publishes new entries: outavail stays 1 if the resulting committed count is > 0.
- Full (free=0): inavail=0. A read in that cycle frees one entry, visible next cycle; a write in that same cycle is still rejected.
- outdata = mem[rd_pos] combinationally; it is valid only while outavail=1.
- Committed + pending + free = DEPTH at all times.
- Tying commit=1 and abort=0 gives plain FIFO behaviour.
- manual_reset overrides all same-cycle strobes.
- rst asserted mid-frame discards pending and committed data immediately.

Optional Feature:
- Macro: FIFO_PKT_HIGHWATER_EN.
- Defined:
  - Adds input hw_clear (1) and output high_water (CNT_W).
  - high_water is a registered maximum of (committed + pending) since the last reset, manual_reset or hw_clear.
  - hw_clear loads the current occupancy.
  - Reset value 0.
- Undefined: neither port exists; no added logic.

Test Plan:
1. Reset, DEPTH=16: write 5 bytes 0x10..0x14, commit, read 5 -> outdata sequence 0x10..0x14, outavail_cnt 5->0, outavail low after the last pop, inavail_cnt back to 16.
2. Write 3 bytes, abort, write 0xAA, commit -> outavail_cnt=1, outdata=0xAA, pending_cnt=0, inavail_cnt=15.
3. Fill 16 with commit, then one extra instrobe -> overflow=1 sticky, inavail=0, almost_full=1. Pop 1 -> inavail=1, inavail_cnt=1, overflow still 1 until manual_reset.
4. Empty FIFO, outstrobe -> underflow=1, counts unchanged. Same-cycle write+commit+read with 1 committed entry -> outavail_cnt stays 1, rd/wr both advance.
5. DEPTH=5, stream 12 bytes through with commit tied high and interleaved reads -> correct order across non-power-of-two wrap; free+committed=5 every cycle.
6. Assert rst asynchronously mid-clock with 4 pending and 3 committed -> all counts and flags at reset values before the next edge. With FIFO_PKT_HIGHWATER_EN defined, high_water=0 after reset and 7 before it.

Source files
------------

// File: rtl/fifo_pkt.sv
// fifo_pkt: packet-aware FIFO with commit/abort of speculative writes.
// Writes land at wr_pos and stay invisible to the reader until a commit moves
// the cm_pos boundary forward; an abort rewinds wr_pos back to cm_pos.
// All flags and counts are registered from next-state values.
// Optional feature macro: FIFO_PKT_HIGHWATER_EN (adds hw_clear / high_water).
module fifo_pkt #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = 2,
    parameter int AEMPTY_THRESH = 2,
    localparam int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             manual_reset,
    input  logic [WIDTH-1:0] indata,
    input  logic             instrobe,
    input  logic             commit,
    input  logic             abort,
    output logic             inavail,
    output logic [CNT_W-1:0] inavail_cnt,
    output logic [WIDTH-1:0] outdata,
    input  logic             outstrobe,
    output logic             outavail,
    output logic [CNT_W-1:0] outavail_cnt,
    output logic [CNT_W-1:0] pending_cnt,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow,
    output logic             underflow
`ifdef FIFO_PKT_HIGHWATER_EN
    ,
    input  logic             hw_clear,
    output logic [CNT_W-1:0] high_water
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic             AF_RST   = (DEPTH <= AFULL_THRESH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_q, wr_d, cm_q, cm_d, rd_q, rd_d;
    logic [PTR_W-1:0] wr_nxt, rd_nxt, wr_adv;
    logic [CNT_W-1:0] cmt_q, cmt_d, pend_q, pend_d, free_q, free_d, pend_inc;
    logic             inavail_q, inavail_d, outavail_q, outavail_d;
    logic             af_q, af_d, ae_q, ae_d, ovf_q, ovf_d, unf_q, unf_d;
    logic             wr_acc, rd_acc;

    // Next-state computation: pointer moves, count bookkeeping and flags.
    always_comb begin
        wr_acc   = instrobe && inavail_q && !abort;
        rd_acc   = outstrobe && outavail_q;
        wr_nxt   = (wr_q == LAST_PTR) ? '0 : wr_q + PTR_W'(1);
        rd_nxt   = (rd_q == LAST_PTR) ? '0 : rd_q + PTR_W'(1);
        wr_adv   = wr_acc ? wr_nxt : wr_q;
        pend_inc = pend_q + CNT_W'(wr_acc);
        rd_d     = rd_acc ? rd_nxt : rd_q;
        ovf_d    = ovf_q | (instrobe && !inavail_q && !abort);
        unf_d    = unf_q | (outstrobe && !outavail_q);
        wr_d     = wr_adv;
        cm_d     = cm_q;
        pend_d   = pend_inc;
        cmt_d    = cmt_q - CNT_W'(rd_acc);
        if (abort) begin
            // Rewind the speculative pointer; any same-cycle write was ignored.
            wr_d   = cm_q;
            pend_d = '0;
        end else if (commit) begin
            // Publish everything written so far, including this cycle's word.
            cm_d   = wr_adv;
            pend_d = '0;
            cmt_d  = cmt_q + pend_inc - CNT_W'(rd_acc);
        end
        if (manual_reset) begin
            wr_d   = '0;
            cm_d   = '0;
            rd_d   = '0;
            pend_d = '0;
            cmt_d  = '0;
            ovf_d  = 1'b0;
            unf_d  = 1'b0;
        end
        free_d     = DEPTH_C - cmt_d - pend_d;
        inavail_d  = (free_d != '0);
        outavail_d = (cmt_d != '0);
        af_d       = (32'(free_d) <= 32'(AFULL_THRESH));
        ae_d       = (32'(cmt_d) <= 32'(AEMPTY_THRESH));
    end

    // State and registered status; rst clears immediately, not at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q       <= '0;
            cm_q       <= '0;
            rd_q       <= '0;
            cmt_q      <= '0;
            pend_q     <= '0;
            free_q     <= DEPTH_C;
            inavail_q  <= 1'b1;
            outavail_q <= 1'b0;
            af_q       <= AF_RST;
            ae_q       <= 1'b1;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wr_q       <= wr_d;
            cm_q       <= cm_d;
            rd_q       <= rd_d;
            cmt_q      <= cmt_d;
            pend_q     <= pend_d;
            free_q     <= free_d;
            inavail_q  <= inavail_d;
            outavail_q <= outavail_d;
            af_q       <= af_d;
            ae_q       <= ae_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // Storage array: written on accepted writes only, never cleared.
    always_ff @(posedge clk) begin
        if (wr_acc && !manual_reset) begin
            mem_q[wr_q] <= indata;
        end
    end

`ifdef FIFO_PKT_HIGHWATER_EN
    logic [CNT_W-1:0] hw_q, hw_d, occ_d;

    // Peak occupancy tracker over committed plus pending entries.
    always_comb begin
        occ_d = cmt_d + pend_d;
        if (manual_reset) begin
            hw_d = '0;
        end else if (hw_clear) begin
            hw_d = occ_d;
        end else begin
            hw_d = (occ_d > hw_q) ? occ_d : hw_q;
        end
    end

    // High-water register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hw_q <= '0;
        end else begin
            hw_q <= hw_d;
        end
    end

    assign high_water = hw_q;
`endif

    assign outdata      = mem_q[rd_q];
    assign inavail      = inavail_q;
    assign inavail_cnt  = free_q;
    assign outavail     = outavail_q;
    assign outavail_cnt = cmt_q;
    assign pending_cnt  = pend_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_pkt.sv
// tb_fifo_pkt: two fifo_pkt instances (DEPTH 16 and DEPTH 5) checked every
// cycle against a queue-based model: one queue holds committed entries
// followed by pending ones, plus a count of how many at the front are committed.
module tb_fifo_pkt;

    typedef logic [7:0] byteq_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: DEPTH 16
    logic       a_mr = 0, a_ins = 0, a_cm = 0, a_ab = 0, a_outs = 0, a_hwc = 0;
    logic [7:0] a_d = 0, a_od;
    logic       a_inav, a_outav, a_af, a_ae, a_ovf, a_unf;
    logic [4:0] a_incnt, a_outcnt, a_pend;
    // Instance B: DEPTH 5
    logic       b_mr = 0, b_ins = 0, b_cm = 0, b_ab = 0, b_outs = 0, b_hwc = 0;
    logic [7:0] b_d = 0, b_od;
    logic       b_inav, b_outav, b_af, b_ae, b_ovf, b_unf;
    logic [2:0] b_incnt, b_outcnt, b_pend;
`ifdef FIFO_PKT_HIGHWATER_EN
    logic [4:0] a_hw;
    logic [2:0] b_hw;
`endif

    fifo_pkt #(.WIDTH(8), .DEPTH(16)) dut_a (
        .clk(clk), .rst(rst), .manual_reset(a_mr), .indata(a_d), .instrobe(a_ins),
        .commit(a_cm), .abort(a_ab), .inavail(a_inav), .inavail_cnt(a_incnt),
        .outdata(a_od), .outstrobe(a_outs), .outavail(a_outav), .outavail_cnt(a_outcnt),
        .pending_cnt(a_pend), .almost_full(a_af), .almost_empty(a_ae),
        .overflow(a_ovf), .underflow(a_unf)
`ifdef FIFO_PKT_HIGHWATER_EN
        , .hw_clear(a_hwc), .high_water(a_hw)
`endif
    );

    fifo_pkt #(.WIDTH(8), .DEPTH(5)) dut_b (
        .clk(clk), .rst(rst), .manual_reset(b_mr), .indata(b_d), .instrobe(b_ins),
        .commit(b_cm), .abort(b_ab), .inavail(b_inav), .inavail_cnt(b_incnt),
        .outdata(b_od), .outstrobe(b_outs), .outavail(b_outav), .outavail_cnt(b_outcnt),
        .pending_cnt(b_pend), .almost_full(b_af), .almost_empty(b_ae),
        .overflow(b_ovf), .underflow(b_unf)
`ifdef FIFO_PKT_HIGHWATER_EN
        , .hw_clear(b_hwc), .high_water(b_hw)
`endif
    );

    // Reference model state
    byteq_t qa, qb;
    int     ca = 0, cb = 0, hwa = 0, hwb = 0;
    bit     oa = 0, ua = 0, ob = 0, ub = 0;
    int     n_cmp = 0, n_mis = 0, ncyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, ncyc);
        end
    endtask

    // One clock edge of the abstract FIFO.
    task automatic model_step(input int depth, inout byteq_t q, inout int ncmt,
                              inout bit ovf, inout bit unf, inout int hw,
                              input bit mr, input bit ins, input bit cm, input bit ab,
                              input bit outs, input logic [7:0] d, input bit hwc);
        int free;
        bit wr;
        free = depth - q.size();
        if (mr) begin
            q.delete();
            ncmt = 0; ovf = 0; unf = 0; hw = 0;
            return;
        end
        wr = ins && (free > 0) && !ab;
        if (ins && free == 0 && !ab) ovf = 1;
        if (outs && ncmt == 0) unf = 1;
        if (outs && ncmt > 0) begin
            void'(q.pop_front());
            ncmt--;
        end
        if (wr) q.push_back(d);
        if (ab) begin
            while (q.size() > ncmt) void'(q.pop_back());
        end else if (cm) begin
            ncmt = q.size();
        end
        if (hwc) hw = q.size();
        else if (q.size() > hw) hw = q.size();
    endtask

    task automatic check_inst(input string p, input int depth, input byteq_t q, input int ncmt,
                              input bit ovf, input bit unf, input int hw,
                              input logic inav, input int incnt, input logic [7:0] od,
                              input logic outav, input int outcnt, input int pend,
                              input logic af, input logic ae, input logic dovf,
                              input logic dunf, input int dhw);
        int free;
        free = depth - q.size();
        check({p, ".inavail"}, 32'(inav), 32'(free > 0));
        check({p, ".inavail_cnt"}, incnt, free);
        check({p, ".outavail"}, 32'(outav), 32'(ncmt > 0));
        check({p, ".outavail_cnt"}, outcnt, ncmt);
        check({p, ".pending_cnt"}, pend, q.size() - ncmt);
        check({p, ".almost_full"}, 32'(af), 32'(free <= 2));
        check({p, ".almost_empty"}, 32'(ae), 32'(ncmt <= 2));
        check({p, ".overflow"}, 32'(dovf), 32'(ovf));
        check({p, ".underflow"}, 32'(dunf), 32'(unf));
        check({p, ".sum"}, incnt + outcnt + pend, depth);
        if (ncmt > 0) check({p, ".outdata"}, 32'(od), 32'(q[0]));
`ifdef FIFO_PKT_HIGHWATER_EN
        check({p, ".high_water"}, dhw, hw);
`else
        if (dhw != 0) check({p, ".high_water_absent"}, dhw, 0);
`endif
    endtask

    task automatic check_all();
        int ahw, bhw;
        ahw = 0; bhw = 0;
`ifdef FIFO_PKT_HIGHWATER_EN
        ahw = int'(a_hw); bhw = int'(b_hw);
`endif
        check_inst("A", 16, qa, ca, oa, ua, hwa, a_inav, int'(a_incnt), a_od, a_outav,
                   int'(a_outcnt), int'(a_pend), a_af, a_ae, a_ovf, a_unf, ahw);
        check_inst("B", 5, qb, cb, ob, ub, hwb, b_inav, int'(b_incnt), b_od, b_outav,
                   int'(b_outcnt), int'(b_pend), b_af, b_ae, b_ovf, b_unf, bhw);
    endtask

    task automatic model_reset();
        qa.delete(); qb.delete();
        ca = 0; cb = 0; oa = 0; ua = 0; ob = 0; ub = 0; hwa = 0; hwb = 0;
    endtask

    // Advance one clock: model follows the edge, outputs checked 1 ns later.
    task automatic cycle();
        @(posedge clk);
        model_step(16, qa, ca, oa, ua, hwa, a_mr, a_ins, a_cm, a_ab, a_outs, a_d, a_hwc);
        model_step(5, qb, cb, ob, ub, hwb, b_mr, b_ins, b_cm, b_ab, b_outs, b_d, b_hwc);
        #1;
        ncyc++;
        $display("cyc %0d A: mr=%b w=%b d=%h c=%b a=%b r=%b -> cmt=%0d pend=%0d | B: mr=%b w=%b d=%h c=%b a=%b r=%b -> cmt=%0d pend=%0d",
                 ncyc, a_mr, a_ins, a_d, a_cm, a_ab, a_outs, a_outcnt, a_pend,
                 b_mr, b_ins, b_d, b_cm, b_ab, b_outs, b_outcnt, b_pend);
        check_all();
    endtask

    task automatic a_op(input bit ins, input logic [7:0] d, input bit cm, input bit ab,
                        input bit outs, input bit mr);
        a_ins = ins; a_d = d; a_cm = cm; a_ab = ab; a_outs = outs; a_mr = mr;
        cycle();
        a_ins = 0; a_cm = 0; a_ab = 0; a_outs = 0; a_mr = 0;
    endtask

    initial begin
        // Reset state, checked before any edge after release
        #12 rst = 1'b0;
        #1 check_all();

        // Write 5, commit, read 5
        for (int i = 0; i < 5; i++) a_op(1, 8'(8'h10 + i), 0, 0, 0, 0);
        a_op(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) a_op(0, 0, 0, 0, 1, 0);

        // Write 3, abort, write 0xAA, commit
        for (int i = 0; i < 3; i++) a_op(1, 8'(8'h20 + i), 0, 0, 0, 0);
        a_op(1, 8'h55, 0, 1, 0, 0);
        a_op(1, 8'hAA, 1, 0, 0, 0);
        a_op(0, 0, 0, 0, 1, 0);

        // Fill to full, overflow attempt, pop one, write+read while full
        for (int i = 0; i < 16; i++) a_op(1, 8'(8'h30 + i), 1, 0, 0, 0);
        a_op(1, 8'hEE, 0, 0, 0, 0);
        a_op(1, 8'hEF, 0, 0, 1, 0);
        a_op(0, 0, 0, 0, 0, 0);
        a_op(0, 0, 0, 0, 0, 1);

        // Underflow on empty, then write+commit+read with one committed
        a_op(0, 0, 0, 0, 1, 0);
        a_op(1, 8'h61, 1, 0, 0, 0);
        a_op(1, 8'h62, 1, 0, 1, 0);
        a_op(1, 8'h63, 1, 1, 1, 0);
        a_op(0, 0, 0, 0, 1, 0);

        // DEPTH 5 streaming with commit tied high
        b_cm = 1;
        for (int i = 0; i < 200; i++) begin
            b_ins = ($urandom_range(99) < 60);
            b_d = 8'($urandom);
            b_outs = ($urandom_range(99) < 50);
            cycle();
        end

        // Randomised packet traffic on both instances
        for (int i = 0; i < 2400; i++) begin
            int pw, pr;
            pw = (i / 600 % 2 == 0) ? 70 : 35;
            pr = (i / 600 % 2 == 0) ? 35 : 70;
            a_ins = ($urandom_range(99) < pw);  a_d = 8'($urandom);
            a_cm = ($urandom_range(99) < 20);   a_ab = ($urandom_range(99) < 6);
            a_outs = ($urandom_range(99) < pr); a_mr = ($urandom_range(999) < 4);
            a_hwc = ($urandom_range(99) < 2);
            b_ins = ($urandom_range(99) < pw);  b_d = 8'($urandom);
            b_cm = ($urandom_range(99) < 25);   b_ab = ($urandom_range(99) < 8);
            b_outs = ($urandom_range(99) < pr); b_mr = ($urandom_range(999) < 4);
            b_hwc = ($urandom_range(99) < 2);
            cycle();
        end
        a_ins = 0; a_cm = 0; a_ab = 0; a_outs = 0; a_mr = 0; a_hwc = 0;
        b_ins = 0; b_cm = 0; b_ab = 0; b_outs = 0; b_mr = 0; b_hwc = 0;

        // Async reset mid-frame: 3 committed, 4 pending on A
        a_op(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) a_op(1, 8'(8'h70 + i), (i == 2), 0, 0, 0);
        for (int i = 0; i < 4; i++) a_op(1, 8'(8'h80 + i), 0, 0, 0, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 model_reset();
        check_all();
        @(posedge clk);
        #1 rst = 1'b0;
        check_all();
        a_op(1, 8'h99, 1, 0, 0, 0);
        a_op(0, 0, 0, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
